// File: rtl/ram_arb_pkg.sv
// Shared types for the unified-RAM arbiter: FSM state and owner encodings,
// plus the default starvation limit used by ram_arbiter.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_MEM   = 1'b1
    } owner_e;

    localparam int STARVE_LIMIT_DEFAULT = 4;

endpackage

// File: rtl/ram_arb_prio.sv
// Owner choice for the next RAM access: MEM wins a collision because it holds
// the older instruction, unless the starvation flag forces a FETCH turn.
module ram_arb_prio
    import ram_arb_pkg::*;
(
    input  logic   fetchReq_i,
    input  logic   memReq_i,
    input  logic   starve_i,
    output logic   anyReq_o,
    output owner_e owner_o
);

    always_comb begin
        anyReq_o = fetchReq_i | memReq_i;
        owner_o  = OWN_FETCH;
        if (memReq_i && !(starve_i && fetchReq_i)) begin
            owner_o = OWN_MEM;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates one single-ported RAM between FETCH reads and MEM loads/stores.
// Define RAM_ARB_STARVE_GUARD_EN to force a FETCH turn after STARVE_LIMIT MEM grants.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 32,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_ack,
    output logic [DATA_W-1:0] fetch_rdata,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              mem_ack,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              ram_ready,
    output logic              grant_mem
);

    state_e            state_q;
    owner_e            owner_q;
    logic              fetchAck_q;
    logic              memAck_q;
    logic              ramEn_q;
    logic              ramWe_q;
    logic [ADDR_W-1:0] ramAddr_q;
    logic [DATA_W-1:0] ramWdata_q;
    logic [DATA_W-1:0] fetchRdata_q;
    logic [DATA_W-1:0] memRdata_q;

    logic              starve;
    logic              anyReq;
    owner_e            nextOwner;

    if (STARVE_LIMIT < 1) begin : gBadStarveLimit
        $error("ram_arbiter: STARVE_LIMIT must be at least 1");
    end

`ifdef RAM_ARB_STARVE_GUARD_EN
    localparam int CntW = $clog2(STARVE_LIMIT + 1);

    logic [CntW-1:0] starveCnt_q;
    logic [CntW-1:0] starveCnt_d;

    assign starve = (starveCnt_q == CntW'(STARVE_LIMIT));

    // Counts back-to-back MEM wins over a waiting FETCH; any other grant restarts it.
    always_comb begin
        starveCnt_d = starveCnt_q;
        if (state_q == IDLE && anyReq) begin
            if (nextOwner == OWN_MEM && fetch_req) begin
                starveCnt_d = starveCnt_q + CntW'(1);
            end else begin
                starveCnt_d = '0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            starveCnt_q <= '0;
        end else begin
            starveCnt_q <= starveCnt_d;
        end
    end
`else
    assign starve = 1'b0;
`endif

    ram_arb_prio uPrio (
        .fetchReq_i (fetch_req),
        .memReq_i   (mem_req),
        .starve_i   (starve),
        .anyReq_o   (anyReq),
        .owner_o    (nextOwner)
    );

    // Acks are raised on the ACCESS->RESP edge so they are high only while in RESP.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            owner_q      <= OWN_FETCH;
            fetchAck_q   <= 1'b0;
            memAck_q     <= 1'b0;
            ramEn_q      <= 1'b0;
            ramWe_q      <= 1'b0;
            ramAddr_q    <= '0;
            ramWdata_q   <= '0;
            fetchRdata_q <= '0;
            memRdata_q   <= '0;
        end else begin
            fetchAck_q <= 1'b0;
            memAck_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (anyReq) begin
                        owner_q <= nextOwner;
                        ramEn_q <= 1'b1;
                        if (nextOwner == OWN_MEM) begin
                            ramWe_q    <= mem_we;
                            ramAddr_q  <= mem_addr;
                            ramWdata_q <= mem_wdata;
                        end else begin
                            ramWe_q    <= 1'b0;
                            ramAddr_q  <= fetch_addr;
                            ramWdata_q <= '0;
                        end
                        state_q <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (ram_ready) begin
                        ramEn_q <= 1'b0;
                        ramWe_q <= 1'b0;
                        if (owner_q == OWN_MEM) begin
                            memAck_q <= 1'b1;
                            if (!ramWe_q) begin
                                memRdata_q <= ram_rdata;
                            end
                        end else begin
                            fetchAck_q   <= 1'b1;
                            fetchRdata_q <= ram_rdata;
                        end
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign fetch_ack   = fetchAck_q;
    assign fetch_rdata = fetchRdata_q;
    assign mem_ack     = memAck_q;
    assign mem_rdata   = memRdata_q;
    assign ram_en      = ramEn_q;
    assign ram_we      = ramWe_q;
    assign ram_addr    = ramAddr_q;
    assign ram_wdata   = ramWdata_q;
    assign grant_mem   = (owner_q == OWN_MEM);

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed plus randomized bench for ram_arbiter with a wait-state RAM model
// and a word-array reference of what every read should return.
module tb_ram_arbiter;

`ifdef RAM_ARB_STARVE_GUARD_EN
    localparam bit GuardOn = 1'b1;
`else
    localparam bit GuardOn = 1'b0;
`endif
    localparam int Limit = 4;

    logic        clock;
    logic        reset;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_ack;
    logic [31:0] fetch_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        ram_en;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        ram_ready;
    logic        grant_mem;

    logic [31:0] ramArr [256];
    logic [31:0] golden [256];
    int          waitCfg;
    bit          idleReady;
    int          passCount;
    int          checkCount;

    ram_arbiter #(.DATA_W(32), .ADDR_W(32), .STARVE_LIMIT(Limit)) dut (
        .clock       (clock),
        .reset       (reset),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_ack   (fetch_ack),
        .fetch_rdata (fetch_rdata),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .ram_en      (ram_en),
        .ram_we      (ram_we),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata),
        .ram_ready   (ram_ready),
        .grant_mem   (grant_mem)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // RAM device: holds ram_ready low for waitCfg cycles of each access.
    initial begin
        int busy;
        busy      = 0;
        ram_ready = 1'b0;
        ram_rdata = '0;
        forever begin
            @(negedge clock);
            if (ram_en) begin
                if (busy < waitCfg) begin
                    ram_ready = 1'b0;
                    ram_rdata = $urandom;
                    busy++;
                end else begin
                    ram_ready = 1'b1;
                    if (ram_we) begin
                        ramArr[ram_addr[9:2]] = ram_wdata;
                        ram_rdata = $urandom;
                    end else begin
                        ram_rdata = ramArr[ram_addr[9:2]];
                    end
                end
            end else begin
                busy      = 0;
                ram_ready = idleReady;
                ram_rdata = $urandom;
            end
        end
    end

    function automatic int idx(input logic [31:0] a);
        return int'(a[9:2]);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    endtask

    task automatic applyStimulus(input logic fr, input logic [31:0] fa, input logic mr,
                                 input logic mw, input logic [31:0] ma, input logic [31:0] md);
        fetch_req  = fr;
        fetch_addr = fa;
        mem_req    = mr;
        mem_we     = mw;
        mem_addr   = ma;
        mem_wdata  = md;
    endtask

    // Returns on the negedge where the wanted ack is seen (or after 40 cycles).
    task automatic waitAck(input string tag, input bit isMem, input int expCycles);
        int n;
        bit seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clock);
            n++;
            seen = isMem ? mem_ack : fetch_ack;
        end
        checkOutput({tag, " latency"}, 32'(n), 32'(expCycles));
        checkOutput({tag, " other ack"}, 32'(isMem ? fetch_ack : mem_ack), 32'd0);
    endtask

    initial begin
        logic [31:0] memModel;
        logic [31:0] fa;
        logic [31:0] ma;
        logic [31:0] md;
        bit          mw;
        bit          lastMem;
        bit          ackSeen;
        int          w;
        int          kind;
        int          n;

        passCount  = 0;
        checkCount = 0;
        waitCfg    = 0;
        idleReady  = 1'b1;
        reset      = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 256; i++) begin
            ramArr[i] = $urandom;
            golden[i] = ramArr[i];
        end
        ramArr[16] = 32'h2008_0005;
        golden[16] = 32'h2008_0005;

        repeat (3) @(negedge clock);
        checkOutput("reset fetch_ack", 32'(fetch_ack), 32'd0);
        checkOutput("reset mem_ack", 32'(mem_ack), 32'd0);
        checkOutput("reset ram_en", 32'(ram_en), 32'd0);
        checkOutput("reset ram_we", 32'(ram_we), 32'd0);
        checkOutput("reset ram_addr", ram_addr, 32'd0);
        checkOutput("reset ram_wdata", ram_wdata, 32'd0);
        checkOutput("reset fetch_rdata", fetch_rdata, 32'd0);
        checkOutput("reset mem_rdata", mem_rdata, 32'd0);
        checkOutput("reset grant_mem", 32'(grant_mem), 32'd0);
        reset = 1'b0;

        $display("[TB] single fetch");
        applyStimulus(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clock);
        checkOutput("fetch ram_en", 32'(ram_en), 32'd1);
        checkOutput("fetch ram_addr", ram_addr, 32'h40);
        checkOutput("fetch ram_we", 32'(ram_we), 32'd0);
        checkOutput("fetch grant_mem", 32'(grant_mem), 32'd0);
        @(negedge clock);
        checkOutput("fetch ack", 32'(fetch_ack), 32'd1);
        checkOutput("fetch rdata", fetch_rdata, 32'h2008_0005);
        checkOutput("fetch mem_ack", 32'(mem_ack), 32'd0);
        applyStimulus(1'b0, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clock);
        checkOutput("fetch ack pulse", 32'(fetch_ack), 32'd0);
        checkOutput("fetch ram_en off", 32'(ram_en), 32'd0);

        $display("[TB] collision");
        applyStimulus(1'b1, 32'h80, 1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF);
        @(negedge clock);
        checkOutput("coll ram_we", 32'(ram_we), 32'd1);
        checkOutput("coll ram_addr", ram_addr, 32'h100);
        checkOutput("coll ram_wdata", ram_wdata, 32'hDEAD_BEEF);
        checkOutput("coll grant_mem", 32'(grant_mem), 32'd1);
        waitAck("coll mem", 1'b1, 1);
        golden[64] = 32'hDEAD_BEEF;
        applyStimulus(1'b1, 32'h80, 1'b0, 1'b0, 32'h0, 32'h0);
        waitAck("coll fetch", 1'b0, 3);
        checkOutput("coll fetch rdata", fetch_rdata, golden[32]);
        checkOutput("coll grant fetch", 32'(grant_mem), 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clock);

        $display("[TB] wait states");
        waitCfg   = 4;
        idleReady = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clock);
            checkOutput($sformatf("wait ram_en c%0d", k), 32'(ram_en), 32'd1);
            checkOutput($sformatf("wait ram_addr c%0d", k), ram_addr, 32'h100);
        end
        @(negedge clock);
        checkOutput("wait mem_ack", 32'(mem_ack), 32'd1);
        checkOutput("wait mem_rdata", mem_rdata, golden[64]);
        checkOutput("wait ram_en off", 32'(ram_en), 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clock);
        checkOutput("wait ack pulse", 32'(mem_ack), 32'd0);

        $display("[TB] reset mid-access");
        waitCfg = 20;
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checkOutput("rst ram_en", 32'(ram_en), 32'd0);
        checkOutput("rst ram_addr", ram_addr, 32'd0);
        checkOutput("rst grant_mem", 32'(grant_mem), 32'd0);
        checkOutput("rst fetch_rdata", fetch_rdata, 32'd0);
        checkOutput("rst mem_rdata", mem_rdata, 32'd0);
        reset = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        ackSeen = 1'b0;
        repeat (8) begin
            @(negedge clock);
            ackSeen = ackSeen | mem_ack | fetch_ack;
        end
        checkOutput("rst no ack", 32'(ackSeen), 32'd0);

        $display("[TB] starvation");
        waitCfg = 0;
        lastMem = 1'b1;
        applyStimulus(1'b1, 32'h40, 1'b1, 1'b0, 32'h100, 32'h0);
        for (int g = 0; g < 10; g++) begin
            n = 0;
            do begin
                @(negedge clock);
                n++;
            end while (!(mem_ack || fetch_ack) && n < 10);
            checkOutput($sformatf("starve latency g%0d", g), 32'(n), (g == 0) ? 32'd2 : 32'd3);
            checkOutput($sformatf("starve owner g%0d", g), 32'(mem_ack),
                        (GuardOn && (g % (Limit + 1) == Limit)) ? 32'd0 : 32'd1);
            lastMem = mem_ack;
        end
        if (lastMem) begin
            applyStimulus(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0);
            waitAck("starve tail fetch", 1'b0, 3);
            checkOutput("starve tail rdata", fetch_rdata, golden[16]);
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clock);

        $display("[TB] data hold");
        applyStimulus(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0);
        waitAck("hold fetch", 1'b0, 2);
        checkOutput("hold fetch rdata", fetch_rdata, golden[16]);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clock);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0);
        waitAck("hold mem rd", 1'b1, 2);
        checkOutput("hold mem rdata", mem_rdata, golden[64]);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clock);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h200, 32'h1234_5678);
        waitAck("hold mem wr", 1'b1, 2);
        checkOutput("hold fetch kept", fetch_rdata, golden[16]);
        checkOutput("hold mem kept", mem_rdata, golden[64]);
        golden[128] = 32'h1234_5678;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clock);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h200, 32'h0);
        waitAck("hold readback", 1'b1, 2);
        checkOutput("hold readback data", mem_rdata, golden[128]);
        memModel = golden[128];
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clock);

        $display("[TB] random traffic");
        for (int t = 0; t < 40; t++) begin
            w         = $urandom_range(0, 3);
            waitCfg   = w;
            idleReady = 1'($urandom_range(0, 1));
            kind      = $urandom_range(0, 2);
            fa        = 32'($urandom_range(0, 255)) << 2;
            ma        = 32'($urandom_range(0, 255)) << 2;
            mw        = 1'($urandom_range(0, 1));
            md        = $urandom;
            if (kind == 0) begin
                applyStimulus(1'b1, fa, 1'b0, 1'b0, 32'h0, 32'h0);
                waitAck($sformatf("rnd%0d fetch", t), 1'b0, 2 + w);
                checkOutput($sformatf("rnd%0d fetch rdata", t), fetch_rdata, golden[idx(fa)]);
            end else begin
                applyStimulus(kind == 2, fa, 1'b1, mw, ma, md);
                waitAck($sformatf("rnd%0d mem", t), 1'b1, 2 + w);
                if (mw) begin
                    golden[idx(ma)] = md;
                end else begin
                    memModel = golden[idx(ma)];
                end
                checkOutput($sformatf("rnd%0d mem rdata", t), mem_rdata, memModel);
                if (kind == 2) begin
                    applyStimulus(1'b1, fa, 1'b0, 1'b0, 32'h0, 32'h0);
                    waitAck($sformatf("rnd%0d fetch2", t), 1'b0, 3 + w);
                    checkOutput($sformatf("rnd%0d fetch2 rdata", t), fetch_rdata, golden[idx(fa)]);
                end
            end
            applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
            @(negedge clock);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
